// File: rtl/morse_decoder_fifo.sv
// Morse decoder: dot/dash/char-space/word-space strobes -> ASCII, queued in a first-word fall-through FIFO.
// Latency: a char is pushed on the edge that samples char/word space and is on out_data the next cycle; a trailing word space follows one edge later.
// Backpressure: out_ready stalls pops only; a push into a full FIFO is dropped and flagged, and the decoder never stalls.
module morse_decoder_fifo #(
    parameter int MAX_SYM    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int CHAR_GAP   = 3,
    parameter int WORD_GAP   = 7,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dot_inp,
    input  logic          dash_inp,
    input  logic          char_space_inp,
    input  logic          word_space_inp,
    input  logic          out_ready,
    input  logic          err_clr,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic [CW-1:0] fifo_count,
    output logic [4:0]    err_pulse,
    output logic [4:0]    err_sticky
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = $clog2(MAX_SYM + 1);
    localparam int GMAX = (WORD_GAP > CHAR_GAP) ? WORD_GAP : CHAR_GAP;
    localparam int GW   = $clog2(GMAX + 1);

    typedef enum logic [0:0] {S_COLLECT = 1'b0, S_GAP = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [MAX_SYM-1:0]   sym_q, sym_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 ovf_q, ovf_d;
    logic [GW-1:0]        cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [4:0]           err_q, err_d, sticky_q;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        count_q;

    logic [2:0]           n_strb;
    logic                 multi, any_strb, push, do_push, do_pop, full;
    logic [7:0]           push_dat;
    logic [8:0]           dec;
    logic                 dec_unk;

    // ITU table lookup; bit 8 = hit. Symbols are dot=0/dash=1, last symbol in the LSB.
    function automatic logic [8:0] decode(input logic [2:0] l, input logic [4:0] s);
        logic [7:0] c;
        logic       hit;
        hit = 1'b1;
        case ({l, s})
            {3'd2, 5'b00001}: c = "A";  {3'd4, 5'b01000}: c = "B";
            {3'd4, 5'b01010}: c = "C";  {3'd3, 5'b00100}: c = "D";
            {3'd1, 5'b00000}: c = "E";  {3'd4, 5'b00010}: c = "F";
            {3'd3, 5'b00110}: c = "G";  {3'd4, 5'b00000}: c = "H";
            {3'd2, 5'b00000}: c = "I";  {3'd4, 5'b00111}: c = "J";
            {3'd3, 5'b00101}: c = "K";  {3'd4, 5'b00100}: c = "L";
            {3'd2, 5'b00011}: c = "M";  {3'd2, 5'b00010}: c = "N";
            {3'd3, 5'b00111}: c = "O";  {3'd4, 5'b00110}: c = "P";
            {3'd4, 5'b01101}: c = "Q";  {3'd3, 5'b00010}: c = "R";
            {3'd3, 5'b00000}: c = "S";  {3'd1, 5'b00001}: c = "T";
            {3'd3, 5'b00001}: c = "U";  {3'd4, 5'b00001}: c = "V";
            {3'd3, 5'b00011}: c = "W";  {3'd4, 5'b01001}: c = "X";
            {3'd4, 5'b01011}: c = "Y";  {3'd4, 5'b01100}: c = "Z";
            {3'd5, 5'b11111}: c = "0";  {3'd5, 5'b01111}: c = "1";
            {3'd5, 5'b00111}: c = "2";  {3'd5, 5'b00011}: c = "3";
            {3'd5, 5'b00001}: c = "4";  {3'd5, 5'b00000}: c = "5";
            {3'd5, 5'b10000}: c = "6";  {3'd5, 5'b11000}: c = "7";
            {3'd5, 5'b11100}: c = "8";  {3'd5, 5'b11110}: c = "9";
            default: begin c = 8'h3F; hit = 1'b0; end
        endcase
        return {hit, c};
    endfunction

    assign n_strb   = 3'(dot_inp) + 3'(dash_inp) + 3'(char_space_inp) + 3'(word_space_inp);
    assign multi    = (n_strb > 3'd1);
    assign any_strb = (n_strb != 3'd0);
    assign dec      = decode(len_q[2:0], sym_q[4:0]);
    assign dec_unk  = ovf_q || (len_q > LW'(5)) || !dec[8];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign do_pop   = out_valid && out_ready;

    // Next-state for symbol collection, gap timing, push request and error pulses
    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        pend_d   = 1'b0;
        push     = 1'b0;
        push_dat = 8'h00;
        err_d    = '0;
        // Trailing space of a word_space that closed a non-empty character
        if (pend_q) begin
            push     = 1'b1;
            push_dat = 8'h20;
        end
        if (multi) err_d[0] = 1'b1;
        case (state_q)
            S_COLLECT: begin
                if (!multi) begin
                    if (dot_inp || dash_inp) begin
                        if (len_q == LW'(MAX_SYM)) begin
                            err_d[2] = 1'b1;
                            ovf_d    = 1'b1;
                        end else begin
                            sym_d = {sym_q[MAX_SYM-2:0], dash_inp};
                            len_d = len_q + LW'(1);
                        end
                    end else if (char_space_inp || word_space_inp) begin
                        if (len_q != '0) begin
                            push     = 1'b1;
                            push_dat = dec_unk ? 8'h3F : dec[7:0];
                            err_d[3] = dec_unk;
                        end
                        if (word_space_inp) begin
                            if (len_q != '0) begin
                                pend_d = 1'b1;
                            end else begin
                                push     = 1'b1;
                                push_dat = 8'h20;
                            end
                            cnt_d = GW'(WORD_GAP);
                        end else begin
                            cnt_d = GW'(CHAR_GAP);
                        end
                        state_d = S_GAP;
                        len_d   = '0;
                        sym_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (any_strb && !multi) err_d[1] = 1'b1;
                if (cnt_q == GW'(1)) state_d = S_COLLECT;
                else                 cnt_d   = cnt_q - GW'(1);
            end
            default: state_d = S_COLLECT;
        endcase
        if (push && full) err_d[4] = 1'b1;
    end

    assign do_push = push && !full;

    // Decoder state, error pulse and sticky registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_COLLECT;
            sym_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            err_q    <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            sym_q    <= sym_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            sticky_q <= err_clr ? err_d : (sticky_q | err_d);
        end
    end

    // FIFO storage; contents need no reset because out_data is gated by occupancy
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_data   = out_valid ? mem_q[rd_q] : 8'h00;
    assign fifo_count = count_q;
    assign err_pulse  = err_q;
    assign err_sticky = sticky_q;
endmodule

// File: tb/tb_morse_decoder_fifo.sv
module tb_morse_decoder_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dot = 1'b0, dash = 1'b0, cs = 1'b0, ws = 1'b0;
    logic       out_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] fifo_count;
    logic [4:0] err_pulse, err_sticky;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [4:0] err_exp_q[$];
    logic       mon_en = 1'b0;

    morse_decoder_fifo #(.MAX_SYM(5), .FIFO_DEPTH(8), .CHAR_GAP(3), .WORD_GAP(7)) dut (
        .clk(clk), .rst(rst_n), .dot_inp(dot), .dash_inp(dash),
        .char_space_inp(cs), .word_space_inp(ws), .out_ready(out_ready), .err_clr(err_clr),
        .out_data(out_data), .out_valid(out_valid), .fifo_count(fifo_count),
        .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle strobe pattern, then all strobes low again
    task automatic drive(input logic d, input logic da, input logic c, input logic w);
        dot = d; dash = da; cs = c; ws = w;
        cyc(1);
        dot = 1'b0; dash = 1'b0; cs = 1'b0; ws = 1'b0;
    endtask

    // 'E' followed by the full character gap
    task automatic send_e(input bit expect_push);
        if (expect_push) exp_q.push_back(8'h45);
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        cyc(3);
    endtask

    // Scoreboard monitor: pops expected data on every handshake, expected error codes on every pulse
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("data_unexpected", {24'h0, out_data}, 32'h100);
                else check("data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
            if (err_pulse != 5'b0) begin
                if (err_exp_q.size() == 0) check("err_unexpected", {27'h0, err_pulse}, 32'h0);
                else check("err_pulse", {27'h0, err_pulse}, {27'h0, err_exp_q.pop_front()});
            end
        end
    end

    initial begin
        cyc(2);
        // Reset state
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", {24'h0, out_data}, 32'h0);
        check("rst_count", {28'h0, fifo_count}, 32'h0);
        check("rst_err", {27'h0, err_pulse}, 32'h0);
        check("rst_sticky", {27'h0, err_sticky}, 32'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc(2);

        // 'A' = .- with consumer ready
        out_ready = 1'b1;
        exp_q.push_back(8'h41);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        check("a_valid", {31'h0, out_valid}, 32'h1);
        check("a_head", {24'h0, out_data}, 32'h41);
        cyc(3);

        // '0' = ----- then word space: 0x30 then 0x20
        out_ready = 1'b0;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h20);
        repeat (5) drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);
        check("ws_count1", {28'h0, fifo_count}, 32'h1);
        cyc(1);
        check("ws_count2", {28'h0, fifo_count}, 32'h2);
        cyc(6);
        out_ready = 1'b1;
        cyc(3);
        check("ws_drained", {28'h0, fifo_count}, 32'h0);

        // Strobe inside char gap is flagged and ignored; next char is 'T' not 'N'
        drive(0, 0, 1, 0);
        check("empty_cs_nopush", {28'h0, fifo_count}, 32'h0);
        cyc(1);
        err_exp_q.push_back(5'b00010);
        drive(1, 0, 0, 0);
        cyc(1);
        exp_q.push_back(8'h54);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        cyc(3);

        // Six dots overflow, then '?' with unknown flag
        repeat (5) drive(1, 0, 0, 0);
        err_exp_q.push_back(5'b00100);
        drive(1, 0, 0, 0);
        err_exp_q.push_back(5'b01000);
        exp_q.push_back(8'h3F);
        drive(0, 0, 1, 0);
        cyc(3);

        // Fill with nine 'E' while stalled: ninth is dropped
        cyc(2);
        out_ready = 1'b0;
        repeat (8) send_e(1'b1);
        check("full_count", {28'h0, fifo_count}, 32'h8);
        err_exp_q.push_back(5'b10000);
        send_e(1'b0);
        check("full_count_after_drop", {28'h0, fifo_count}, 32'h8);
        out_ready = 1'b1;
        cyc(10);
        check("full_drained", {28'h0, fifo_count}, 32'h0);

        // Dot then dot+dash in one cycle: only multi flagged, length stays 1 -> 'E'
        err_exp_q.push_back(5'b00001);
        exp_q.push_back(8'h45);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 1, 0);
        cyc(3);

        // Word space with empty character pushes a lone space
        exp_q.push_back(8'h20);
        drive(0, 0, 0, 1);
        cyc(7);

        // Every error class has fired; err_clr wipes the sticky flags
        check("sticky_all", {27'h0, err_sticky}, 32'h1f);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("sticky_cleared", {27'h0, err_sticky}, 32'h0);

        // Reset mid-word with three entries queued
        out_ready = 1'b0;
        repeat (3) send_e(1'b1);
        drive(1, 0, 0, 0);
        check("pre_rst_count", {28'h0, fifo_count}, 32'h3);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_count", {28'h0, fifo_count}, 32'h0);
        check("mid_rst_data", {24'h0, out_data}, 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        out_ready = 1'b1;
        send_e(1'b1);
        cyc(4);
        check("post_rst_count", {28'h0, fifo_count}, 32'h0);

        check("sb_data_left", exp_q.size(), 32'h0);
        check("sb_err_left", err_exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
